// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds and one-cycle overflow/underflow pulses. Read data is registered.
module fifo_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_LEVEL   = 14,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     din,
  input  logic                      we,
  input  logic                      re,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [AW:0] DepthC = (AW+1)'(DEPTH);
  localparam logic [AW:0] AfC    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AeC    = (AW+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_ok, wr_ok;

  // Flags decode the registered count, so they settle right after the edge.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DepthC);
  assign almost_empty = (count_q <= AeC);
  assign almost_full  = (count_q >= AfC);

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_ok = re && !empty;
  assign wr_ok = we && (!full || rd_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    overflow_d  = we && !wr_ok;
    underflow_d = re && !rd_ok;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q];
    end
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; reset only blocks a write in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout      = dout_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: a reference queue model feeds a scoreboard of expected
// read data, plus a vector table for the fill/overflow phase and corner sequences.
module tb_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk;
  logic          rst;
  logic [DW-1:0] din;
  logic          we;
  logic          re;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;

  fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .we           (we),
    .re           (re),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mdout;
  int            mcount;
  logic          movf;
  logic          munf;

  typedef struct {
    logic          we;
    logic          re;
    logic [DW-1:0] din;
    int            cnt;
    logic          ae;
    logic          af;
    logic          full;
    logic          ovf;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    if (exp_q.size() > 0) mdout = exp_q.pop_front();
    chk("dout",         32'(dout),         32'(mdout));
    chk("count",        32'(count),        32'(mcount));
    chk("empty",        32'(empty),        32'(mcount == 0));
    chk("full",         32'(full),         32'(mcount == DEPTH));
    chk("almost_empty", 32'(almost_empty), 32'(mcount <= AE));
    chk("almost_full",  32'(almost_full),  32'(mcount >= AF));
    chk("overflow",     32'(overflow),     32'(movf));
    chk("underflow",    32'(underflow),    32'(munf));
  endtask

  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    logic rok;
    logic wok;
    we  = w;
    re  = r;
    din = d;
    rok = r && (mcount != 0);
    wok = w && ((mcount != DEPTH) || rok);
    @(posedge clk);
    if (rok) exp_q.push_back(mq.pop_front());
    if (wok) mq.push_back(d);
    mcount = mq.size();
    movf   = w && !wok;
    munf   = r && !rok;
    #1;
    check_model();
  endtask

  task automatic reset_step(input logic w, input logic r, input logic [DW-1:0] d);
    rst = 1'b1;
    we  = w;
    re  = r;
    din = d;
    @(posedge clk);
    mq.delete();
    exp_q.delete();
    mdout  = '0;
    mcount = 0;
    movf   = 1'b0;
    munf   = 1'b0;
    #1;
    check_model();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    we  = 1'b0;
    re  = 1'b0;
    din = '0;

    for (int i = 0; i < 16; i++) begin
      tbl[i].we   = 1'b1;
      tbl[i].re   = 1'b0;
      tbl[i].din  = 8'(i);
      tbl[i].cnt  = i + 1;
      tbl[i].ae   = (i + 1) <= 2;
      tbl[i].af   = (i + 1) >= 14;
      tbl[i].full = (i + 1) == 16;
      tbl[i].ovf  = 1'b0;
    end
    tbl[16] = '{we: 1'b1, re: 1'b0, din: 8'hAA, cnt: 16, ae: 1'b0, af: 1'b1, full: 1'b1,
                ovf: 1'b1};
    tbl[17] = '{we: 1'b0, re: 1'b0, din: 8'h00, cnt: 16, ae: 1'b0, af: 1'b1, full: 1'b1,
                ovf: 1'b0};

    // Reset held two cycles
    reset_step(1'b0, 1'b0, '0);
    reset_step(1'b0, 1'b0, '0);
    chk("rst_dout",  32'(dout),  32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_ae",    32'(almost_empty), 32'h1);
    chk("rst_full",  32'(full),  32'h0);
    chk("rst_af",    32'(almost_full), 32'h0);
    chk("rst_ovf",   32'(overflow), 32'h0);
    chk("rst_unf",   32'(underflow), 32'h0);

    // Fill and overflow from the vector table
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].we, tbl[i].re, tbl[i].din);
      chk("tbl_count", 32'(count),        32'(tbl[i].cnt));
      chk("tbl_ae",    32'(almost_empty), 32'(tbl[i].ae));
      chk("tbl_af",    32'(almost_full),  32'(tbl[i].af));
      chk("tbl_full",  32'(full),         32'(tbl[i].full));
      chk("tbl_ovf",   32'(overflow),     32'(tbl[i].ovf));
    end

    // Drain: 0..15 in order, then one rejected read
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, '0);
      chk("drain_data", 32'(dout), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'h1);
    step(1'b0, 1'b1, '0);
    chk("unf_pulse", 32'(underflow), 32'h1);
    chk("unf_hold",  32'(dout),      32'h0F);
    step(1'b0, 1'b0, '0);
    chk("unf_clear", 32'(underflow), 32'h0);

    // Wrap: 24 writes with a read every other cycle, then top up to full
    for (int i = 0; i < 24; i++) step(1'b1, (i % 2) == 1, 8'(8'h40 + i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
    chk("wrap_full", 32'(full), 32'h1);
    step(1'b1, 1'b1, 8'h77);
    chk("full_wr_rd_full",  32'(full),     32'h1);
    chk("full_wr_rd_count", 32'(count),    32'd16);
    chk("full_wr_rd_ovf",   32'(overflow), 32'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0);
    chk("wrap_last", 32'(dout), 32'h77);
    step(1'b1, 1'b1, 8'h88);
    chk("empty_wr_rd_count", 32'(count),     32'd1);
    chk("empty_wr_rd_unf",   32'(underflow), 32'h1);
    chk("empty_wr_rd_dout",  32'(dout),      32'h77);
    step(1'b0, 1'b1, '0);
    chk("empty_wr_rd_data",  32'(dout),      32'h88);

    // Mid-operation reset with we=re=1 discards everything
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    reset_step(1'b1, 1'b1, 8'hEE);
    chk("midrst_count", 32'(count), 32'h0);
    chk("midrst_empty", 32'(empty), 32'h1);
    chk("midrst_dout",  32'(dout),  32'h0);
    step(1'b1, 1'b0, 8'h5A);
    step(1'b0, 1'b1, '0);
    chk("post_rst_data", 32'(dout), 32'h5A);
    step(1'b0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
